issue_scoreboard: RTL
=====================

// Module: issue_scoreboard
// PURPOSE
//  Issue-side RAW hazard tracker for the dual-issue pipeline (I -> E -> M1 -> M2 -> M3 -> WB).
//  - Records every issued register write as it moves through E..M3.
//  - Decides whether each issue slot's operands can be forwarded when the slot enters E:
//    either from the forwarding network, or from the regfile once the producer has left M3.
//  - Produces per-slot issue_ok and issue_fire.
//  - This is the producer-tracking end of the forwarding path: the forwarding network only
//    delivers the data this block has already declared ready.
// PARAMETERS
//  NSTAGE  4  tracked stages after issue (E, M1, M2, M3); stage index 0 = E
//  AW      5  register address width (creg_addr_t)
//  SLOTS   2  issue width; fixed at 2, other values unsupported
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high
//  issue_valid  in   2        issue queue head slots hold valid instructions; slot0 is older
//  issue_in     in   2xsb_issue_t  per slot: ra1, ra2, rdst, regwrite, rdy_stg[1:0]
//  stall_e      in   1        pipeline hold: freeze all tracker state, no issue
//  flush_lvl    in   2        0 = none, 1 = kill issue + E, 2 = kill issue + E + M1, 3 = reserved (treated as 2)
//  issue_ok     out  2        slot i operands forwardable on E entry
//  issue_fire   out  2        slot i issues this cycle
//  pair_split   out  1        slot1 held only because of an intra-bundle dependency on slot0
// BEHAVIOUR
//  State
//  - Table ent[stage 0..3][slot 0..1] of sb_entry_t {valid, rdst, rdy_stg}.
//  - Reset: all valid = 0. All outputs are combinational from state and inputs, so after
//    reset: issue_ok = 2'b11, and issue_fire = issue_valid (when no stall and no flush).
//  Matching an operand ra
//  - Register 0 never matches.
//  - Search youngest first: E slot1, E slot0, M1 slot1, ..., M3 slot0.
//  - An entry matches when valid && rdst == ra.
//  - First match at stage s is ready iff s >= rdy_stg. A non-ready youngest match blocks
//    the operand even if an older match is ready.
//  - No match: ready (value comes from the regfile; WB writes are write-first).
//  Issue rules
//  - rdy_stg encoding: 0 = ALU, 1 = M1 result, 2 = load, 3 = mul/hi/lo/cp0.
//  - issue_ok[0] = ra1 ready && ra2 ready, checked against the table.
//  - issue_ok[1] = table check passes && no intra-bundle RAW.
//    Intra-bundle RAW: slot0.regwrite && slot0.rdst != 0 && slot0.rdst is slot1.ra1 or slot1.ra2.
//  - pair_split = issue_valid[1] && table check for slot1 passes && intra-bundle RAW present.
//  - issue_fire[0] = issue_valid[0] & issue_ok[0] & ~stall_e & (flush_lvl == 0).
//  - issue_fire[1] = issue_fire[0] & issue_valid[1] & issue_ok[1]. Slot1 never issues alone.
//  Update each cycle
//  - Step 1, kill: flush_lvl >= 1 clears valid in stage 0; flush_lvl >= 2 also clears stage 1.
//  - Step 2, advance: if ~stall_e, shift 0 -> 1 -> 2 -> 3 and drop the M3 entries.
//    Stage 0 loads {issue_fire[i] & regwrite & rdst != 0, rdst, rdy_stg}.
//    If stall_e, entries hold (kills still apply).
//  - Flush and stall together: kill applies, no shift.
//  - WAW in flight: both entries are kept; youngest-first search resolves it.
//  - Reset mid-operation clears everything in one cycle. Flush needs no drain.
// STRUCTURE
//  - pipes.svh: sb_issue_t, sb_entry_t, and the rdy_stg encoding localparams RDY_E, RDY_M1, RDY_M2, RDY_M3.
//  - Sub-module sb_match: combinational youngest-first search, instantiated 4x (2 slots x ra1/ra2).
//    Input: flattened table + ra; outputs: hit, ready.
// TESTING
//  1. Reset, then slot0 addu $3 (rdy 0), slot1 lw $4 (rdy 2)
//     -> both fire; next cycle an instruction reading $3 gets issue_ok = 1.
//  2. lw $5 issued at cycle t; dependent reads $5
//     -> issue_ok = 0 at t+1 and t+2 (producer in E, M1); issue_ok = 1 at t+3 (M2).
//  3. Bundle {addu $6, ..; subu .., $6, ..}
//     -> issue_fire = 2'b01, pair_split = 1; slot1 issues next cycle with issue_ok = 1.
//  4. mul $7 (rdy 3) then addu $7 (rdy 0) one cycle apart; reader of $7 one cycle later
//     -> ready (youngest addu in E). Swap the order (addu, then mul)
//     -> not ready until the mul reaches M3.
//  5. mul $8 in E, stall_e held 3 cycles
//     -> table frozen; reader of $8 stays not ready; ready exactly 3 unstalled cycles later.
//  6. lw $9 in M1, flush_lvl = 2
//     -> entry cleared; reader of $9 is ok next cycle. flush_lvl = 1 with a producer in M1
//     -> that entry survives.
//     Also: any read of $0 -> always ok.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue-side RAW scoreboard: issue-slot fields, tracker entries
// and the stage at which each kind of producer has its result on the forwarding network.
package issue_scoreboard_pkg;

   localparam int NSTAGE = 4;
   localparam int AW     = 5;
   localparam int SLOTS  = 2;
   localparam int NENT   = NSTAGE * SLOTS;

   typedef logic [AW-1:0] creg_addr_t;

   // rdy_stg: first tracked stage (0 = E) at which the producer's result can be forwarded
   localparam logic [1:0] RDY_E  = 2'd0;
   localparam logic [1:0] RDY_M1 = 2'd1;
   localparam logic [1:0] RDY_M2 = 2'd2;
   localparam logic [1:0] RDY_M3 = 2'd3;

   typedef struct packed {
      creg_addr_t ra1;
      creg_addr_t ra2;
      creg_addr_t rdst;
      logic       regwrite;
      logic [1:0] rdy_stg;
   } sb_issue_t;

   typedef struct packed {
      logic       valid;
      creg_addr_t rdst;
      logic [1:0] rdy_stg;
   } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_match.sv
// Youngest-first producer search for one source operand over the flattened tracker table.
// ready is only meaningful when hit is set; it reports whether that youngest producer forwards.
module sb_match
   import issue_scoreboard_pkg::*;
(
   input  sb_entry_t [NENT-1:0] tbl,
   input  creg_addr_t           ra,
   output logic                 hit,
   output logic                 ready
);

   // Walk oldest to youngest so the last match written is the youngest one
   always_comb begin
      hit   = 1'b0;
      ready = 1'b0;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (ra != '0 && tbl[s*SLOTS+k].valid && tbl[s*SLOTS+k].rdst == ra) begin
               hit   = 1'b1;
               ready = (2'(s) >= tbl[s*SLOTS+k].rdy_stg);
            end
         end
      end
   end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue RAW hazard scoreboard: tracks in-flight register writes from E to M3 and
// gates each issue slot on whether its operands can be forwarded on entry to E.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic      [SLOTS-1:0] issue_valid,
   input  sb_issue_t [SLOTS-1:0] issue_in,
   input  logic                  stall_e,
   input  logic            [1:0] flush_lvl,
   output logic      [SLOTS-1:0] issue_ok,
   output logic      [SLOTS-1:0] issue_fire,
   output logic                  pair_split
);

   sb_entry_t [NENT-1:0] ent;
   sb_entry_t [NENT-1:0] killed;
   sb_entry_t [NENT-1:0] ent_nxt;

   creg_addr_t ra [4];
   logic [3:0] hit;
   logic [3:0] hit_rdy;
   logic [3:0] op_ok;
   logic       tbl_ok0;
   logic       tbl_ok1;
   logic       intra_raw;

   assign ra[0] = issue_in[0].ra1;
   assign ra[1] = issue_in[0].ra2;
   assign ra[2] = issue_in[1].ra1;
   assign ra[3] = issue_in[1].ra2;

   for (genvar g = 0; g < 4; g++) begin : g_match
      sb_match u_match (
         .tbl   (ent),
         .ra    (ra[g]),
         .hit   (hit[g]),
         .ready (hit_rdy[g])
      );
   end

   // No producer in flight means the regfile (write-first at WB) supplies the value
   assign op_ok   = ~hit | hit_rdy;
   assign tbl_ok0 = op_ok[0] & op_ok[1];
   assign tbl_ok1 = op_ok[2] & op_ok[3];

   assign intra_raw = issue_in[0].regwrite && (issue_in[0].rdst != '0) &&
                      ((issue_in[0].rdst == issue_in[1].ra1) ||
                       (issue_in[0].rdst == issue_in[1].ra2));

   assign issue_ok      = {tbl_ok1 & ~intra_raw, tbl_ok0};
   assign pair_split    = issue_valid[1] & tbl_ok1 & intra_raw;
   assign issue_fire[0] = issue_valid[0] & issue_ok[0] & ~stall_e & (flush_lvl == 2'd0);
   assign issue_fire[1] = issue_fire[0] & issue_valid[1] & issue_ok[1];

   // Kill first, then shift; a stall holds the table but kills still land
   always_comb begin
      killed = ent;
      for (int k = 0; k < SLOTS; k++) begin
         if (flush_lvl != 2'd0) killed[k].valid = 1'b0;
         if (flush_lvl[1])      killed[SLOTS+k].valid = 1'b0;
      end

      ent_nxt = killed;
      if (!stall_e) begin
         for (int s = NSTAGE - 1; s >= 1; s--) begin
            for (int k = 0; k < SLOTS; k++) begin
               ent_nxt[s*SLOTS+k] = killed[(s-1)*SLOTS+k];
            end
         end
         for (int k = 0; k < SLOTS; k++) begin
            ent_nxt[k].valid   = issue_fire[k] & issue_in[k].regwrite & (issue_in[k].rdst != '0);
            ent_nxt[k].rdst    = issue_in[k].rdst;
            ent_nxt[k].rdy_stg = issue_in[k].rdy_stg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ent <= '0;
      end else begin
         ent <= ent_nxt;
      end
   end

endmodule
